mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 The module SHALL provide these ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  pipeline access request; sampled only in IDLE.
- op_i  in  4  0=LB, 1=LBU, 2=LH, 3=LHU, 4=LW, 8=SB, 9=SH, 10=SW; any other value is illegal.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-aligned.
- busy_o  out  1  stall to pipeline; high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  load result; valid while done_o=1.
- err_o  out  1  misaligned address or illegal op; valid while done_o=1.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  1  RAM write enable.
- ram_addr_o  out  32  word address, {addr[31:2],2'b00}.
- ram_sel_o  out  4  byte-lane enables; bit k selects bits [8k+7:8k].
- ram_data_o  out  32  lane-replicated store data.
- ram_data_i  in  32  RAM read data; combinational from ram_addr_o.
REQ-002 The single clock port SHALL be clk, and the reset port SHALL be rst: synchronous, active-high.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-004 In IDLE with req_i=1 at a rising edge, the block SHALL register op_i, addr_i and wdata_i.
- Legal, aligned request: the next state SHALL be ISSUE.
- Misaligned address or illegal op: the next state SHALL be RESP with err latched to 1.
REQ-005 Misalignment SHALL be defined as follows: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; byte operations are never misaligned.
REQ-006 In ISSUE, the outputs SHALL be driven from registered values only:
- ram_ce_o=1.
- ram_we_o=1 for stores, 0 for loads.
- ram_addr_o is the word address.
- ram_sel_o, ram_data_o per REQ-007.
ISSUE SHALL last exactly one cycle; the next state SHALL be RESP.
REQ-007 Lane rules (o=addr[1:0]):
- Byte access: sel=1<<o; data={4{wdata[7:0]}}.
- Half access: sel=0011 (o=0) or 1100 (o=2); data={2{wdata[15:0]}}.
- Word access: sel=1111; data=wdata.
REQ-008 A store SHALL be written by the RAM at the rising edge ending ISSUE.
REQ-009 For a load, ram_data_i SHALL be captured at the rising edge ending ISSUE. The selected byte or half SHALL then be extracted:
- LB/LH: sign-extended to 32 bits.
- LBU/LHU: zero-extended to 32 bits.
- LW: the full word.
REQ-010 In RESP, the block SHALL drive done_o=1 for exactly one cycle, with rdata_o (0 for stores and for errors) and err_o. The next state SHALL be IDLE.
REQ-011 Outside ISSUE, the block SHALL drive ram_ce_o=0, ram_we_o=0, ram_sel_o=0, ram_addr_o=0 and ram_data_o=0.
REQ-012 An error response SHALL never assert ram_ce_o.
REQ-013 Latency SHALL be 2 cycles from acceptance to done_o for legal accesses and 1 cycle for errors.
REQ-014 req_i SHALL be ignored while busy_o=1. A new request SHALL be accepted only at an edge where the state is IDLE. Back-to-back throughput SHALL therefore be one access per 3 cycles.
REQ-015 rdata_o and err_o SHALL hold their value after done_o falls, until the next RESP.

Reset
REQ-016 rst=1 at a rising edge SHALL force the state to IDLE from any state.
REQ-017 After a reset edge, all outputs SHALL be 0: busy_o, done_o, rdata_o, err_o and all ram_* outputs.
REQ-018 Reset during ISSUE or RESP SHALL abort the access, with no done_o pulse.
REQ-019 A store whose ISSUE cycle coincides with rst=1 SHALL still be written by the RAM at that edge, because the RAM is not reset.
REQ-020 Reset SHALL take priority over req_i at the same edge.

Verification
REQ-021 SW 0x00000104, wdata=0x11223344 -> in ISSUE: ce=1, we=1, sel=1111, data=0x11223344, addr=0x104; done_o two cycles after acceptance.
REQ-022 SB 0x00000106, wdata=0x000000A5 -> sel=0100, data=0xA5A5A5A5; a subsequent LW 0x104 returns 0x11A53344.
REQ-023 With word 0x80FF7F01 at 0x200:
- LB 0x201 -> 0x0000007F.
- LB 0x202 -> 0xFFFFFFFF.
- LBU 0x203 -> 0x00000080.
- LH 0x202 -> 0xFFFF80FF.
- LHU 0x200 -> 0x00007F01.
REQ-024 LW 0x102, SH 0x101 and op=5 -> done_o one cycle after acceptance, err_o=1, rdata_o=0, ram_ce_o never 1.
REQ-025 req_i held at 1 continuously with alternating SW/LW -> exactly one done_o per 3 cycles; busy_o low only in IDLE.
REQ-026 rst asserted during a load's ISSUE -> next cycle all outputs 0, no done_o; a new request is accepted on the following edge.

Source files
------------

// File: rtl/mem_ctrl.sv
// ==== mem_ctrl: byte/half/word load-store sequencer for a single-port RAM (rev 1.0) ====
`default_nettype none

module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  function automatic logic op_legal(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10: return 1'b1;
      default:                                         return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] op_size(input logic [3:0] op);
    case (op)
      4'd0, 4'd1, 4'd8: return SZ_BYTE;
      4'd2, 4'd3, 4'd9: return SZ_HALF;
      default:          return SZ_WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [3:0] op, input logic [1:0] ofs);
    case (op_size(op))
      SZ_HALF: return ofs[0];
      SZ_WORD: return |ofs;
      default: return 1'b0;
    endcase
  endfunction

  logic accept;
  logic acc_bad;
  assign accept  = (state == IDLE) && req_i;
  assign acc_bad = !op_legal(op_i) || misaligned(op_i, addr_i[1:0]);

  // Lane steering and load extraction work only on the registered request.
  logic [1:0]  size_q;
  logic [1:0]  ofs_q;
  logic        is_store_q;
  logic [3:0]  lane_sel;
  logic [31:0] lane_data;
  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        ld_signed;
  logic [31:0] load_val;

  assign size_q     = op_size(op_q);
  assign ofs_q      = addr_q[1:0];
  assign is_store_q = op_q[3];
  assign shifted    = ram_data_i >> {ofs_q, 3'b000};
  assign ld_byte    = shifted[7:0];
  assign ld_half    = ofs_q[1] ? ram_data_i[31:16] : ram_data_i[15:0];
  assign ld_signed  = !op_q[0];

  always_comb begin
    lane_sel  = 4'b1111;
    lane_data = wdata_q;
    load_val  = ram_data_i;
    case (size_q)
      SZ_BYTE: begin
        lane_sel  = 4'b0001 << ofs_q;
        lane_data = {4{wdata_q[7:0]}};
        load_val  = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        lane_sel  = ofs_q[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata_q[15:0]}};
        load_val  = {{16{ld_signed & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = 32'h0;
    ram_sel_o  = 4'h0;
    ram_data_o = 32'h0;
    case (state)
      IDLE: begin
        busy_o = 1'b0;
        if (req_i) state_nxt = acc_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        ram_ce_o   = 1'b1;
        ram_we_o   = is_store_q;
        ram_addr_o = {addr_q[31:2], 2'b00};
        ram_sel_o  = lane_sel;
        ram_data_o = lane_data;
        state_nxt  = RESP;
      end
      RESP: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Result registers change only on the edge entering RESP, so they hold between responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 4'h0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_i;
        addr_q  <= addr_i;
        wdata_q <= wdata_i;
        if (acc_bad) begin
          rdata_q <= 32'h0;
          err_q   <= 1'b1;
        end
      end
      if (state == ISSUE) begin
        rdata_q <= is_store_q ? 32'h0 : load_val;
        err_q   <= 1'b0;
      end
    end
  end

  assign rdata_o = rdata_q;
  assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// ==== tb_mem_ctrl: directed vector bench for mem_ctrl with a behavioural byte-lane RAM (rev 1.0) ====
`default_nettype none

module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy_o, done_o, err_o;
  logic [31:0] rdata_o;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .op_i       (op),
    .addr_i     (addr),
    .wdata_i    (wdata),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .rdata_o    (rdata_o),
    .err_o      (err_o),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o),
    .ram_data_i (ram_data_i)
  );

  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_ce_o && ram_we_o)
      for (int k = 0; k < 4; k++)
        if (ram_sel_o[k]) mem[ram_addr_o[9:2]][8*k +: 8] <= ram_data_o[8*k +: 8];
  end
  assign ram_data_i = mem[ram_addr_o[9:2]];

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  sel;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_busy"}, 32'(busy_o), 32'h0);
    check({pfx, "_done"}, 32'(done_o), 32'h0);
    check({pfx, "_rdata"}, rdata_o, 32'h0);
    check({pfx, "_err"}, 32'(err_o), 32'h0);
    check({pfx, "_ce"}, 32'(ram_ce_o), 32'h0);
    check({pfx, "_we"}, 32'(ram_we_o), 32'h0);
    check({pfx, "_addr"}, ram_addr_o, 32'h0);
    check({pfx, "_sel"}, 32'(ram_sel_o), 32'h0);
    check({pfx, "_data"}, ram_data_o, 32'h0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_busy", 32'(busy_o), 32'h0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    logic        saw_ce;
    logic        we_c;
    logic [3:0]  sel_c;
    logic [31:0] data_c, addr_c;
    wait_idle();
    req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
    @(posedge clk); #1;
    req = 1'b0;
    lat = 1; saw_ce = 1'b0; we_c = 1'b0; sel_c = 4'h0; data_c = 32'h0; addr_c = 32'h0;
    while (!done_o && lat < 8) begin
      if (ram_ce_o) begin
        saw_ce = 1'b1; we_c = ram_we_o; sel_c = ram_sel_o;
        data_c = ram_data_o; addr_c = ram_addr_o;
      end
      @(posedge clk); #1;
      lat++;
    end
    if (ram_ce_o) saw_ce = 1'b1;
    check($sformatf("v%0d_latency", idx), 32'(lat), v.err ? 32'd1 : 32'd2);
    check($sformatf("v%0d_rdata", idx), rdata_o, v.rdata);
    check($sformatf("v%0d_err", idx), 32'(err_o), 32'(v.err));
    if (v.err) begin
      check($sformatf("v%0d_ce_seen", idx), 32'(saw_ce), 32'h0);
    end else begin
      check($sformatf("v%0d_we", idx), 32'(we_c), 32'(v.op[3]));
      check($sformatf("v%0d_sel", idx), 32'(sel_c), 32'(v.sel));
      check($sformatf("v%0d_wrdata", idx), data_c, v.data);
      check($sformatf("v%0d_addr", idx), addr_c, {v.addr[31:2], 2'b00});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int   dones;
    vec_t v;

    //           op     addr          wdata          rdata          err   sel     ram data
    vecs[0]  = '{4'd10, 32'h00000104, 32'h11223344, 32'h00000000, 1'b0, 4'hF, 32'h11223344};
    vecs[1]  = '{4'd8,  32'h00000106, 32'h000000A5, 32'h00000000, 1'b0, 4'h4, 32'hA5A5A5A5};
    vecs[2]  = '{4'd4,  32'h00000104, 32'h00000000, 32'h11A53344, 1'b0, 4'hF, 32'h00000000};
    vecs[3]  = '{4'd9,  32'h00000106, 32'h1234BEEF, 32'h00000000, 1'b0, 4'hC, 32'hBEEFBEEF};
    vecs[4]  = '{4'd4,  32'h00000104, 32'h00000000, 32'hBEEF3344, 1'b0, 4'hF, 32'h00000000};
    vecs[5]  = '{4'd10, 32'h00000200, 32'h80FF7F01, 32'h00000000, 1'b0, 4'hF, 32'h80FF7F01};
    vecs[6]  = '{4'd0,  32'h00000201, 32'h00000000, 32'h0000007F, 1'b0, 4'h2, 32'h00000000};
    vecs[7]  = '{4'd0,  32'h00000202, 32'h00000000, 32'hFFFFFFFF, 1'b0, 4'h4, 32'h00000000};
    vecs[8]  = '{4'd1,  32'h00000203, 32'h00000000, 32'h00000080, 1'b0, 4'h8, 32'h00000000};
    vecs[9]  = '{4'd2,  32'h00000202, 32'h00000000, 32'hFFFF80FF, 1'b0, 4'hC, 32'h00000000};
    vecs[10] = '{4'd3,  32'h00000200, 32'h00000000, 32'h00007F01, 1'b0, 4'h3, 32'h00000000};
    vecs[11] = '{4'd4,  32'h00000102, 32'h00000000, 32'h00000000, 1'b1, 4'h0, 32'h00000000};
    vecs[12] = '{4'd9,  32'h00000101, 32'h00005555, 32'h00000000, 1'b1, 4'h0, 32'h00000000};
    vecs[13] = '{4'd5,  32'h00000200, 32'h00000000, 32'h00000000, 1'b1, 4'h0, 32'h00000000};

    rst = 1'b1; req = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Error result must persist after the done pulse.
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("err_hold_done", 32'(done_o), 32'h0);
    check("err_hold_err", 32'(err_o), 32'h1);

    // req held high, alternating SW/LW: one access per three cycles.
    wait_idle();
    req = 1'b1; op = 4'd10; addr = 32'h300; wdata = 32'hCAFE0001;
    dones = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check($sformatf("b2b%0d_busy", k), 32'(busy_o), (k % 3 != 2) ? 32'h1 : 32'h0);
      check($sformatf("b2b%0d_done", k), 32'(done_o), (k % 3 == 1) ? 32'h1 : 32'h0);
      if (done_o) dones++;
      if (k % 3 == 1 && op == 4'd4) check($sformatf("b2b%0d_rdata", k), rdata_o, 32'hCAFE0001);
      if (k % 3 == 2) op = (op == 4'd10) ? 4'd4 : 4'd10;
    end
    req = 1'b0;
    check("b2b_done_count", 32'(dones), 32'd4);

    // Store whose ISSUE edge coincides with reset still lands in RAM.
    wait_idle();
    req = 1'b1; op = 4'd8; addr = 32'h300; wdata = 32'h00000077;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_st_issue_we", 32'(ram_we_o), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_st_done", 32'(done_o), 32'h0);
    check("rst_st_busy", 32'(busy_o), 32'h0);
    v = '{4'd4, 32'h00000300, 32'h0, 32'hCAFE0077, 1'b0, 4'hF, 32'h0};
    run_vec(v, 100);

    // Reset during a load's ISSUE, with req also high: reset wins, then next edge accepts.
    wait_idle();
    req = 1'b1; op = 4'd4; addr = 32'h104; wdata = 32'h0;
    @(posedge clk); #1;
    check("rst_ld_issue_ce", 32'(ram_ce_o), 32'h1);
    rst = 1'b1; addr = 32'h200;
    @(posedge clk); #1;
    check_zero("rst_ld");
    rst = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    check("rst_ld_accept_busy", 32'(busy_o), 32'h1);
    check("rst_ld_accept_ce", 32'(ram_ce_o), 32'h1);
    check("rst_ld_accept_addr", ram_addr_o, 32'h200);
    @(posedge clk); #1;
    check("rst_ld_done", 32'(done_o), 32'h1);
    check("rst_ld_rdata", rdata_o, 32'h80FF7F01);
    @(posedge clk); #1;
    check("hold_done", 32'(done_o), 32'h0);
    check("hold_rdata", rdata_o, 32'h80FF7F01);
    check("hold_err", 32'(err_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
